// File: rtl/decode_pkg.sv
// MIPS main-decoder constants, control bundle layout and the enqueue-time decode function.
// Optional macro DECODE_CP0_EN enables MTC0/MFC0/ERET decoding; otherwise that opcode is invalid.
package decode_pkg;

    localparam int unsigned CTRL_W  = 23;
    localparam int unsigned ALUOP_W = 4;

    // Control bundle bit positions, MSB to LSB
    localparam int unsigned CTRL_REGWRITE_BIT   = 22;
    localparam int unsigned CTRL_MEMTOREG_BIT   = 21;
    localparam int unsigned CTRL_REGDST_BIT     = 20;
    localparam int unsigned CTRL_ALUSRC_BIT     = 19;
    localparam int unsigned CTRL_MEMEN_BIT      = 18;
    localparam int unsigned CTRL_BRANCH_BIT     = 17;
    localparam int unsigned CTRL_BAL_BIT        = 16;
    localparam int unsigned CTRL_JUMP_BIT       = 15;
    localparam int unsigned CTRL_JAL_BIT        = 14;
    localparam int unsigned CTRL_JR_BIT         = 13;
    localparam int unsigned CTRL_JALR_BIT       = 12;
    localparam int unsigned CTRL_HILO_WRITE_BIT = 11;
    localparam int unsigned CTRL_HILO_READ_BIT  = 10;
    localparam int unsigned CTRL_CP0WE_BIT      = 9;
    localparam int unsigned CTRL_CP0R_BIT       = 8;
    localparam int unsigned CTRL_SYSCALL_BIT    = 7;
    localparam int unsigned CTRL_BRK_BIT        = 6;
    localparam int unsigned CTRL_ERET_BIT       = 5;
    localparam int unsigned CTRL_INVALID_BIT    = 4;
    localparam int unsigned CTRL_ALUOP_MSB      = 3;
    localparam int unsigned CTRL_ALUOP_LSB      = 0;

    // Opcodes
    localparam logic [5:0] EXE_SPECIAL_INST  = 6'b000000;
    localparam logic [5:0] EXE_REGIMM_INST   = 6'b000001;
    localparam logic [5:0] EXE_J             = 6'b000010;
    localparam logic [5:0] EXE_JAL           = 6'b000011;
    localparam logic [5:0] EXE_BEQ           = 6'b000100;
    localparam logic [5:0] EXE_BNE           = 6'b000101;
    localparam logic [5:0] EXE_BLEZ          = 6'b000110;
    localparam logic [5:0] EXE_BGTZ          = 6'b000111;
    localparam logic [5:0] EXE_ADDI          = 6'b001000;
    localparam logic [5:0] EXE_ADDIU         = 6'b001001;
    localparam logic [5:0] EXE_SLTI          = 6'b001010;
    localparam logic [5:0] EXE_SLTIU         = 6'b001011;
    localparam logic [5:0] EXE_ANDI          = 6'b001100;
    localparam logic [5:0] EXE_ORI           = 6'b001101;
    localparam logic [5:0] EXE_XORI          = 6'b001110;
    localparam logic [5:0] EXE_LUI           = 6'b001111;
    localparam logic [5:0] EXE_SPECIAL3_INST = 6'b010000;
    localparam logic [5:0] EXE_LB            = 6'b100000;
    localparam logic [5:0] EXE_LH            = 6'b100001;
    localparam logic [5:0] EXE_LW            = 6'b100011;
    localparam logic [5:0] EXE_LBU           = 6'b100100;
    localparam logic [5:0] EXE_LHU           = 6'b100101;
    localparam logic [5:0] EXE_SB            = 6'b101000;
    localparam logic [5:0] EXE_SH            = 6'b101001;
    localparam logic [5:0] EXE_SW            = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] EXE_SLL     = 6'b000000;
    localparam logic [5:0] EXE_SRL     = 6'b000010;
    localparam logic [5:0] EXE_SRA     = 6'b000011;
    localparam logic [5:0] EXE_SLLV    = 6'b000100;
    localparam logic [5:0] EXE_SRLV    = 6'b000110;
    localparam logic [5:0] EXE_SRAV    = 6'b000111;
    localparam logic [5:0] EXE_JR      = 6'b001000;
    localparam logic [5:0] EXE_JALR    = 6'b001001;
    localparam logic [5:0] EXE_SYSCALL = 6'b001100;
    localparam logic [5:0] EXE_BREAK   = 6'b001101;
    localparam logic [5:0] EXE_MFHI    = 6'b010000;
    localparam logic [5:0] EXE_MTHI    = 6'b010001;
    localparam logic [5:0] EXE_MFLO    = 6'b010010;
    localparam logic [5:0] EXE_MTLO    = 6'b010011;
    localparam logic [5:0] EXE_MULT    = 6'b011000;
    localparam logic [5:0] EXE_MULTU   = 6'b011001;
    localparam logic [5:0] EXE_DIV     = 6'b011010;
    localparam logic [5:0] EXE_DIVU    = 6'b011011;
    localparam logic [5:0] EXE_ADD     = 6'b100000;
    localparam logic [5:0] EXE_ADDU    = 6'b100001;
    localparam logic [5:0] EXE_SUB     = 6'b100010;
    localparam logic [5:0] EXE_SUBU    = 6'b100011;
    localparam logic [5:0] EXE_AND     = 6'b100100;
    localparam logic [5:0] EXE_OR      = 6'b100101;
    localparam logic [5:0] EXE_XOR     = 6'b100110;
    localparam logic [5:0] EXE_NOR     = 6'b100111;
    localparam logic [5:0] EXE_SLT     = 6'b101010;
    localparam logic [5:0] EXE_SLTU    = 6'b101011;

    // REGIMM rt codes and CP0 rs codes
    localparam logic [4:0]  EXE_BLTZ   = 5'b00000;
    localparam logic [4:0]  EXE_BGEZ   = 5'b00001;
    localparam logic [4:0]  EXE_BLTZAL = 5'b10000;
    localparam logic [4:0]  EXE_BGEZAL = 5'b10001;
    localparam logic [4:0]  EXE_MTC0   = 5'b00100;
    localparam logic [4:0]  EXE_MFC0   = 5'b00000;
    localparam logic [31:0] EXE_ERET   = 32'h4200_0018;

    // ALU operation classes; R-type ops are resolved from funct downstream
    localparam logic [ALUOP_W-1:0] R_TYPE_OP  = 4'd0;
    localparam logic [ALUOP_W-1:0] ADDI_OP    = 4'd1;
    localparam logic [ALUOP_W-1:0] ADDIU_OP   = 4'd2;
    localparam logic [ALUOP_W-1:0] SLTI_OP    = 4'd3;
    localparam logic [ALUOP_W-1:0] SLTIU_OP   = 4'd4;
    localparam logic [ALUOP_W-1:0] ANDI_OP    = 4'd5;
    localparam logic [ALUOP_W-1:0] ORI_OP     = 4'd6;
    localparam logic [ALUOP_W-1:0] XORI_OP    = 4'd7;
    localparam logic [ALUOP_W-1:0] LUI_OP     = 4'd8;
    localparam logic [ALUOP_W-1:0] MTC0_OP    = 4'd9;
    localparam logic [ALUOP_W-1:0] MFC0_OP    = 4'd10;
    localparam logic [ALUOP_W-1:0] USELESS_OP = 4'd15;

    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic               regdst;
        logic               alusrc;
        logic               memen;
        logic               branch;
        logic               bal;
        logic               jump;
        logic               jal;
        logic               jr;
        logic               jalr;
        logic               hilo_write;
        logic               hilo_read;
        logic               cp0we;
        logic               cp0r;
        logic               syscall;
        logic               brk;
        logic               eret;
        logic               invalid;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        ctrl_t       ctrl;
    } entry_t;

    function automatic ctrl_t invalid_ctrl();
        ctrl_t c;
        c         = '0;
        c.invalid = 1'b1;
        c.aluop   = USELESS_OP;
        return c;
    endfunction

    function automatic ctrl_t decode_instr(input logic [31:0] instr);
        ctrl_t      c;
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       unused_fields;
        op            = instr[31:26];
        rs            = instr[25:21];
        rt            = instr[20:16];
        funct         = instr[5:0];
        unused_fields = ^{rs, instr[15:6]};
        c             = '0;
        c.aluop       = USELESS_OP;
        case (op)
            EXE_SPECIAL_INST: begin
                c.aluop = R_TYPE_OP;
                case (funct)
                    EXE_SLL, EXE_SRL, EXE_SRA, EXE_SLLV, EXE_SRLV, EXE_SRAV,
                    EXE_ADD, EXE_ADDU, EXE_SUB, EXE_SUBU, EXE_AND, EXE_OR,
                    EXE_XOR, EXE_NOR, EXE_SLT, EXE_SLTU: begin
                        c.regwrite = 1'b1;
                        c.regdst   = 1'b1;
                    end
                    EXE_MFHI, EXE_MFLO: begin
                        c.regwrite  = 1'b1;
                        c.regdst    = 1'b1;
                        c.hilo_read = 1'b1;
                    end
                    EXE_MTHI, EXE_MTLO, EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU:
                        c.hilo_write = 1'b1;
                    EXE_JR:      c.jr = 1'b1;
                    EXE_JALR: begin
                        c.jalr     = 1'b1;
                        c.regwrite = 1'b1;
                        c.regdst   = 1'b1;
                    end
                    EXE_SYSCALL: c.syscall = 1'b1;
                    EXE_BREAK:   c.brk     = 1'b1;
                    default:     c = invalid_ctrl();
                endcase
            end
            EXE_REGIMM_INST: begin
                case (rt)
                    EXE_BLTZ, EXE_BGEZ: c.branch = 1'b1;
                    EXE_BLTZAL, EXE_BGEZAL: begin
                        c.branch   = 1'b1;
                        c.bal      = 1'b1;
                        c.regwrite = 1'b1;
                    end
                    default: c = invalid_ctrl();
                endcase
            end
            EXE_J: c.jump = 1'b1;
            EXE_JAL: begin
                c.jal      = 1'b1;
                c.regwrite = 1'b1;
            end
            EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ: c.branch = 1'b1;
            EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU,
            EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                case (op)
                    EXE_ADDI:  c.aluop = ADDI_OP;
                    EXE_ADDIU: c.aluop = ADDIU_OP;
                    EXE_SLTI:  c.aluop = SLTI_OP;
                    EXE_SLTIU: c.aluop = SLTIU_OP;
                    EXE_ANDI:  c.aluop = ANDI_OP;
                    EXE_ORI:   c.aluop = ORI_OP;
                    EXE_XORI:  c.aluop = XORI_OP;
                    default:   c.aluop = LUI_OP;
                endcase
            end
            EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                c.alusrc   = 1'b1;
                c.memen    = 1'b1;
                c.aluop    = ADDI_OP;
            end
            EXE_SB, EXE_SH, EXE_SW: begin
                c.alusrc = 1'b1;
                c.memen  = 1'b1;
                c.aluop  = ADDI_OP;
            end
            EXE_SPECIAL3_INST: begin
`ifdef DECODE_CP0_EN
                if (instr == EXE_ERET) begin
                    c.eret = 1'b1;
                end else if (rs == EXE_MTC0) begin
                    c.cp0we = 1'b1;
                    c.aluop = MTC0_OP;
                end else if (rs == EXE_MFC0) begin
                    c.cp0r     = 1'b1;
                    c.regwrite = 1'b1;
                    c.aluop    = MFC0_OP;
                end else begin
                    c = invalid_ctrl();
                end
`else
                c = invalid_ctrl();
`endif
            end
            default: c = invalid_ctrl();
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x WIDTH FIFO with occupancy count, flush, and a registered zero-when-empty head.
module decode_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             ready_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    // Next-state: the head register looks one cycle ahead so out_* are flop outputs
    always_comb begin
        do_push  = push_i && ready_q && !flush_i;
        do_pop   = pop_i && valid_q && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
        valid_d = (count_d != '0);
        ready_d = (count_d != CNT_W'(DEPTH));
        // New head is the word being written when it lands in the slot rd_ptr_d selects
        if (!valid_d)                            head_d = '0;
        else if (do_push && rd_ptr_d == wr_ptr_q) head_d = wdata_i;
        else                                     head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset: it is only read under count/valid control
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign rdata_o = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes fetched instructions at enqueue and buffers them with valid/ready handshakes.
// CP0 instruction decoding is controlled by DECODE_CP0_EN (see decode_pkg).
module decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned ENTRY_W = $bits(entry_t);

    entry_t wr_entry;
    entry_t rd_entry;

    always_comb begin
        wr_entry.instr = in_instr;
        wr_entry.pc    = in_pc;
        wr_entry.ctrl  = decode_instr(in_instr);
    end

    decode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (in_valid),
        .wdata_i (wr_entry),
        .ready_o (in_ready),
        .pop_i   (out_ready),
        .valid_o (out_valid),
        .rdata_o (rd_entry),
        .flush_i (flush),
        .count_o (count)
    );

    assign out_instr = rd_entry.instr;
    assign out_pc    = rd_entry.pc;
    assign out_ctrl  = rd_entry.ctrl;

endmodule

// File: tb/tb_decode_queue.sv
// Directed + random bench for decode_queue with a scoreboard queue of expected entries.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int N_TAB = 14;

    localparam logic [31:0] I_ADDIU  = 32'h2401_0005;
    localparam logic [31:0] I_SLL    = 32'h0000_0000;
    localparam logic [31:0] I_BADOP  = 32'h7C00_0000;
    localparam logic [31:0] I_LW     = 32'h8C22_0004;
    localparam logic [31:0] I_SW     = 32'hAC22_0008;
    localparam logic [31:0] I_BEQ    = 32'h1022_0003;
    localparam logic [31:0] I_ADDU   = 32'h0022_1821;
    localparam logic [31:0] I_MULT   = 32'h0022_0018;
    localparam logic [31:0] I_ERET   = 32'h4200_0018;
    localparam logic [31:0] I_JAL    = 32'h0C00_0010;
    localparam logic [31:0] I_MFC0   = 32'h4002_6000;
    localparam logic [31:0] I_MTC0   = 32'h4082_6000;
    localparam logic [31:0] I_BADFN  = 32'h0000_003F;
    localparam logic [31:0] I_BGEZAL = 32'h0431_0004;

    localparam logic [31:0] TAB [N_TAB] = '{I_ADDIU, I_SLL, I_BADOP, I_LW, I_SW, I_BEQ, I_ADDU,
                                            I_MULT, I_ERET, I_JAL, I_MFC0, I_MTC0, I_BADFN, I_BGEZAL};

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [22:0] ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [22:0] out_ctrl;
    logic [2:0]  count;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .count     (count)
    );

    // Hand-derived control words (bit 22 regwrite ... bit 4 invalid, [3:0] aluop)
    function automatic logic [22:0] ref_ctrl(input logic [31:0] w);
        case (w)
            I_ADDIU:  return 23'h48_0002;
            I_SLL:    return 23'h50_0000;
            I_LW:     return 23'h6C_0001;
            I_SW:     return 23'h0C_0001;
            I_BEQ:    return 23'h02_000F;
            I_ADDU:   return 23'h50_0000;
            I_MULT:   return 23'h00_0800;
            I_JAL:    return 23'h40_400F;
            I_BGEZAL: return 23'h43_000F;
`ifdef DECODE_CP0_EN
            I_ERET:   return 23'h00_002F;
            I_MFC0:   return 23'h40_010A;
            I_MTC0:   return 23'h00_0209;
`endif
            default:  return 23'h00_001F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("count", 32'(count), 32'(sb.size()));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
        if (sb.size() != 0) begin
            check("head_instr", out_instr, sb[0].instr);
            check("head_pc", out_pc, sb[0].pc);
            check("head_ctrl", 32'(out_ctrl), 32'(sb[0].ctrl));
        end else begin
            check("empty_instr", out_instr, 32'd0);
            check("empty_pc", out_pc, 32'd0);
            check("empty_ctrl", 32'(out_ctrl), 32'd0);
        end
    endtask

    // One clock: drive inputs, advance, update scoreboard, compare
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl, input logic rs);
        logic push_ok;
        logic pop_ok;
        exp_t e;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        rst       = rs;
        push_ok   = v && (sb.size() < DEPTH) && !fl;
        pop_ok    = rdy && (sb.size() != 0) && !fl;
        e.instr   = ins;
        e.pc      = pc;
        e.ctrl    = ref_ctrl(ins);
        @(posedge clk);
        #1;
        if (rs || fl) begin
            sb.delete();
        end else begin
            if (pop_ok)  void'(sb.pop_front());
            if (push_ok) sb.push_back(e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
        check_outputs();
    endtask

    initial begin
        logic [3:0]  idx;
        logic        v;
        logic        r;
        logic        f;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        cycle(1'b1, I_ADDIU, 32'h1000, 1'b0, 1'b0, 1'b0);
        check("addiu_valid", 32'(out_valid), 32'd1);
        check("addiu_regwrite", 32'(out_ctrl[22]), 32'd1);
        check("addiu_alusrc", 32'(out_ctrl[19]), 32'd1);
        check("addiu_aluop", 32'(out_ctrl[3:0]), 32'd2);
        check("addiu_invalid", 32'(out_ctrl[4]), 32'd0);
        check("addiu_count", 32'(count), 32'd1);

        cycle(1'b1, I_SLL,   32'h1004, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, I_BADOP, 32'h1008, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, I_LW,    32'h100C, 1'b0, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);

        cycle(1'b1, I_SW, 32'h1010, 1'b0, 1'b0, 1'b0);
        check("full_reject_pc", out_pc, 32'h1000);
        check("full_reject_count", 32'(count), 32'd4);

        // Full with simultaneous pop: no pass-through of the offered word
        cycle(1'b1, I_SW, 32'h1010, 1'b1, 1'b0, 1'b0);
        check("full_pop_count", 32'(count), 32'd3);
        check("sll_invalid", 32'(out_ctrl[4]), 32'd0);
        check("sll_regwrite", 32'(out_ctrl[22]), 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("badop_invalid", 32'(out_ctrl[4]), 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("drained_valid", 32'(out_valid), 32'd0);

        cycle(1'b1, I_ERET, 32'h2000, 1'b0, 1'b0, 1'b0);
`ifdef DECODE_CP0_EN
        check("eret_bit", 32'(out_ctrl[5]), 32'd1);
`else
        check("eret_invalid", 32'(out_ctrl[4]), 32'd1);
`endif
        cycle(1'b1, I_MFC0, 32'h2004, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Steady push+pop across the pointer wrap
        cycle(1'b1, TAB[0], 32'h3000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, TAB[1], 32'h3004, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idx = 4'((i + 2) % N_TAB);
            cycle(1'b1, TAB[idx], 32'h3008 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
            check("stream_count", 32'(count), 32'd2);
        end

        cycle(1'b1, I_BEQ, 32'h4000, 1'b0, 1'b0, 1'b0);
        check("preflush_count", 32'(count), 32'd3);
        cycle(1'b1, I_JAL, 32'h4004, 1'b1, 1'b1, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ctrl", 32'(out_ctrl), 32'd0);

        cycle(1'b1, I_LW, 32'h5000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, I_SW, 32'h5004, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, I_ADDU, 32'h5008, 1'b1, 1'b0, 1'b1);
        check("midrst_count", 32'(count), 32'd0);

        for (int i = 0; i < 80; i++) begin
            idx = 4'($urandom_range(0, N_TAB - 1));
            v   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            f   = ($urandom_range(0, 19) == 0);
            cycle(v, TAB[idx], 32'h6000 + 32'(i * 4), r, f, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
